// File: rtl/spart_sdram_loader_if.sv
// ---------------------------------------------------------------------------
// spart_sdram_loader_if
// Bus between the SPART frame loader and the SDRAM controller's spart write
// port: transaction request/grant, frame address window with its load strobe,
// and the per-word write push with its FIFO-full back-pressure.
//   trxn_req   : loader -> controller, held for the whole data phase
//   trxn_grant : controller -> loader, pushes allowed only while high
//   wr_full    : controller -> loader, write FIFO full
//   wr_req     : loader -> controller, one cycle per 16-bit word
//   wr_data    : loader -> controller, word being pushed
//   start_addr : loader -> controller, first word address of the frame
//   end_addr   : loader -> controller, last word address of the frame
//   load_addr  : loader -> controller, 1-cycle strobe for start/end_addr
// Modports: master = loader side, slave = controller side.
// ---------------------------------------------------------------------------
interface spart_sdram_loader_if #(
  parameter int ADDR_W = 25
);
  logic              trxn_req;
  logic              trxn_grant;
  logic              wr_full;
  logic              wr_req;
  logic [15:0]       wr_data;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              load_addr;

  modport master (
    output trxn_req, wr_req, wr_data, start_addr, end_addr, load_addr,
    input  trxn_grant, wr_full
  );

  modport slave (
    input  trxn_req, wr_req, wr_data, start_addr, end_addr, load_addr,
    output trxn_grant, wr_full
  );
endinterface

// File: rtl/spart_sdram_loader.sv
// ---------------------------------------------------------------------------
// spart_sdram_loader
// Parses a framed byte stream from the SPART receiver and feeds the SDRAM
// controller's spart write port. Frame layout:
//   4 address bytes (big-endian, truncated to ADDR_W bits)
//   2 word-count bytes N (big-endian)
//   2N data bytes, low byte of each word first
//   optional checksum byte (XOR of every preceding frame byte)
// Ports:
//   ref_clk     : sole clock (spart_ref_clk from the controller)
//   rst_n       : synchronous active-low reset
//   rx_data     : received byte, valid when rx_valid strobes
//   rx_valid    : 1-cycle byte strobe
//   bus         : master side of spart_sdram_loader_if (controller port)
//   busy        : frame in progress
//   done        : 1-cycle pulse when a frame completes
//   err_overrun : sticky, a byte was dropped because a word was still pending
//   err_csum    : sticky, checksum byte mismatch (0 unless checksum enabled)
// Configuration:
//   SPART_LOADER_CSUM_EN defined -> trailing checksum byte is expected and
//   checked in an extra CSUM state. Undefined -> frame ends at the last data
//   byte and err_csum is tied low.
// Assumes WCNT_W <= ADDR_W <= 32.
// ---------------------------------------------------------------------------
module spart_sdram_loader #(
  parameter int ADDR_W = 25,
  parameter int WCNT_W = 16
) (
  input  logic                 ref_clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  spart_sdram_loader_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err_overrun,
  output logic                 err_csum
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    REQ,
    DATA,
`ifdef SPART_LOADER_CSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  state_t            state;
  logic [2:0]        hdr_cnt;
  logic [39:0]       hdr_sr;
  logic [WCNT_W-1:0] frame_words;
  logic [WCNT_W-1:0] words_rx;
  logic [WCNT_W-1:0] words_tx;
  logic [7:0]        lo_byte;
  logic              lo_full;
  logic [15:0]       pend_word;
  logic              pend_valid;

  logic              push;
  logic              last_push;
  logic              data_byte;
  logic [ADDR_W-1:0] frame_addr;
  logic [WCNT_W-1:0] hdr_words;

`ifdef SPART_LOADER_CSUM_EN
  logic [7:0]        csum_acc;
  logic              csum_got;
  logic              err_csum_q;
  logic              csum_byte;
`endif

  // When the sixth header byte arrives, the first five sit in hdr_sr
  // (byte 0 in the top octet), so address and count are assembled here.
  assign frame_addr = ADDR_W'(hdr_sr[39:8]);
  assign hdr_words  = WCNT_W'({hdr_sr[7:0], rx_data});

  // The push is qualified combinationally by the live grant/full inputs so
  // wr_req can never appear in a cycle where the controller cannot accept.
  assign push      = (state == DATA) && pend_valid && bus.trxn_grant && !bus.wr_full;
  assign last_push = push && (words_tx == frame_words - WCNT_W'(1));
  assign data_byte = rx_valid && ((state == REQ) || (state == DATA)) &&
                     (words_rx != frame_words);

  assign bus.wr_req  = push;
  assign bus.wr_data = pend_word;

`ifdef SPART_LOADER_CSUM_EN
  // The checksum byte is the first byte after every data word has been
  // assembled, whether or not the last word has been pushed yet.
  assign csum_byte = rx_valid && !csum_got && (words_rx == frame_words) &&
                     ((state == REQ) || (state == DATA) || (state == CSUM));
  assign err_csum  = err_csum_q;
`else
  assign err_csum  = 1'b0;
`endif

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      hdr_cnt        <= '0;
      hdr_sr         <= '0;
      frame_words    <= '0;
      words_rx       <= '0;
      words_tx       <= '0;
      lo_byte        <= '0;
      lo_full        <= 1'b0;
      pend_word      <= '0;
      pend_valid     <= 1'b0;
      bus.trxn_req   <= 1'b0;
      bus.start_addr <= '0;
      bus.end_addr   <= '0;
      bus.load_addr  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_overrun    <= 1'b0;
`ifdef SPART_LOADER_CSUM_EN
      csum_acc       <= '0;
      csum_got       <= 1'b0;
      err_csum_q     <= 1'b0;
`endif
    end else begin
      bus.load_addr <= 1'b0;
      done          <= 1'b0;

      if (push) begin
        pend_valid <= 1'b0;
        words_tx   <= words_tx + WCNT_W'(1);
      end

      // Word assembly. An odd byte may replace a word that is leaving this
      // very cycle; otherwise a second complete word has nowhere to go and
      // the byte is dropped.
      if (data_byte) begin
        if (!lo_full) begin
          lo_byte <= rx_data;
          lo_full <= 1'b1;
        end else if (!pend_valid || push) begin
          pend_word  <= {rx_data, lo_byte};
          pend_valid <= 1'b1;
          lo_full    <= 1'b0;
          words_rx   <= words_rx + WCNT_W'(1);
        end else begin
          err_overrun <= 1'b1;
        end
      end

`ifdef SPART_LOADER_CSUM_EN
      if (data_byte) begin
        csum_acc <= csum_acc ^ rx_data;
      end
      if (csum_byte) begin
        csum_got <= 1'b1;
        if (rx_data != csum_acc) begin
          err_csum_q <= 1'b1;
        end
      end
`endif

      case (state)
        IDLE: begin
          if (rx_valid) begin
            state       <= HDR;
            hdr_cnt     <= 3'd1;
            hdr_sr      <= {hdr_sr[31:0], rx_data};
            busy        <= 1'b1;
            err_overrun <= 1'b0;
            words_rx    <= '0;
            words_tx    <= '0;
            lo_full     <= 1'b0;
            pend_valid  <= 1'b0;
`ifdef SPART_LOADER_CSUM_EN
            csum_acc    <= rx_data;
            csum_got    <= 1'b0;
            err_csum_q  <= 1'b0;
`endif
          end
        end

        HDR: begin
          if (rx_valid) begin
            hdr_sr  <= {hdr_sr[31:0], rx_data};
            hdr_cnt <= hdr_cnt + 3'd1;
`ifdef SPART_LOADER_CSUM_EN
            csum_acc <= csum_acc ^ rx_data;
`endif
            if (hdr_cnt == 3'd5) begin
              bus.start_addr <= frame_addr;
              bus.end_addr   <= frame_addr + ADDR_W'(hdr_words) - ADDR_W'(1);
              bus.load_addr  <= 1'b1;
              frame_words    <= hdr_words;
              if (hdr_words == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state        <= REQ;
                bus.trxn_req <= 1'b1;
              end
            end
          end
        end

        REQ: begin
          if (bus.trxn_grant) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (last_push) begin
            bus.trxn_req <= 1'b0;
`ifdef SPART_LOADER_CSUM_EN
            state <= CSUM;
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end
        end

`ifdef SPART_LOADER_CSUM_EN
        CSUM: begin
          if (csum_got) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
`endif

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_sdram_loader.sv
// ---------------------------------------------------------------------------
// tb_spart_sdram_loader
// Self-checking bench for spart_sdram_loader: a table of frames with known
// address windows, hand-written back-pressure / overrun / reset sequences,
// and randomized frames under random grant/full. Expected words and address
// windows come from the frame bytes the bench itself builds.
// Honors SPART_LOADER_CSUM_EN by appending (and optionally corrupting) the
// checksum byte.
// ---------------------------------------------------------------------------
module tb_spart_sdram_loader;

  localparam int ADDR_W = 25;
  localparam int WCNT_W = 16;

  logic       ref_clk  = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       busy;
  logic       done;
  logic       err_overrun;
  logic       err_csum;

  spart_sdram_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

  spart_sdram_loader #(.ADDR_W(ADDR_W), .WCNT_W(WCNT_W)) dut (
    .ref_clk    (ref_clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .bus        (bus_if.master),
    .busy       (busy),
    .done       (done),
    .err_overrun(err_overrun),
    .err_csum   (err_csum)
  );

  always #5 ref_clk = ~ref_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Controller-side monitor, sampled on the falling edge.
  logic [15:0]       mon_words[$];
  int                load_cnt   = 0;
  int                done_cnt   = 0;
  int                req_cycles = 0;
  logic [ADDR_W-1:0] cap_start  = '0;
  logic [ADDR_W-1:0] cap_end    = '0;
  logic              req_at_done = 1'b0;

  always @(negedge ref_clk) begin
    if (rst_n) begin
      if (bus_if.wr_req) begin
        mon_words.push_back(bus_if.wr_data);
        checkOutput("wr_req_legal", {62'd0, bus_if.wr_full, !bus_if.trxn_grant}, 64'd0);
      end
      if (bus_if.load_addr) begin
        load_cnt++;
        cap_start = bus_if.start_addr;
        cap_end   = bus_if.end_addr;
      end
      if (done) begin
        done_cnt++;
        req_at_done = bus_if.trxn_req;
      end
      if (bus_if.trxn_req) req_cycles++;
    end
  end

  // Random grant/full driver; every third cycle is forced open so a pending
  // word always leaves well before the next word can complete.
  bit rand_bus = 1'b0;
  int bus_cyc  = 0;
  initial begin
    forever begin
      @(posedge ref_clk);
      #1;
      if (rand_bus) begin
        bus_cyc++;
        if (bus_cyc % 3 == 0) begin
          bus_if.trxn_grant = 1'b1;
          bus_if.wr_full    = 1'b0;
        end else begin
          bus_if.trxn_grant = ($urandom_range(0, 3) != 0);
          bus_if.wr_full    = ($urandom_range(0, 2) == 0);
        end
      end
    end
  end

  logic [7:0] data_q[$];
  logic [7:0] tb_xor;

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tb_xor   = tb_xor ^ b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] a, input int n, input int gap);
    logic [7:0] hb[6];
    hb[0] = a[31:24]; hb[1] = a[23:16]; hb[2] = a[15:8]; hb[3] = a[7:0];
    hb[4] = 8'(n >> 8); hb[5] = 8'(n);
    for (int i = 0; i < 6; i++) begin
      send_byte(hb[i]);
      repeat (gap) tick();
    end
  endtask

  task automatic send_csum(input bit corrupt);
`ifdef SPART_LOADER_CSUM_EN
    logic [7:0] c;
    c = corrupt ? ~tb_xor : tb_xor;
    send_byte(c);
`else
    if (corrupt) rx_data = rx_data;
`endif
  endtask

  task automatic clear_mon();
    mon_words.delete();
    load_cnt   = 0;
    done_cnt   = 0;
    req_cycles = 0;
    tb_xor     = 8'h00;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < 500) begin
      tick();
      cyc++;
    end
    checkOutput({tag, "_done_in_time"}, 64'(cyc < 500), 64'd1);
    repeat (2) tick();
  endtask

  task automatic fill_random(input int n);
    data_q.delete();
    for (int i = 0; i < 2 * n; i++) data_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference address window: plain modular arithmetic on the frame fields.
  function automatic logic [ADDR_W-1:0] model_start(input logic [31:0] a);
    longint unsigned m, v;
    m = 64'd1 << ADDR_W;
    v = {32'd0, a} % m;
    return v[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] model_end(input logic [31:0] a, input int n);
    longint unsigned m, v;
    m = 64'd1 << ADDR_W;
    v = ({32'd0, a} % m + m + longint'(n) - 1) % m;
    return v[ADDR_W-1:0];
  endfunction

  // Sends one complete frame carrying data_q and checks everything the
  // controller should have seen.
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input int n,
                               input logic [ADDR_W-1:0] exp_start,
                               input logic [ADDR_W-1:0] exp_end,
                               input int gap, input bit corrupt);
    logic [15:0] exp_w;
    bit          exp_csum_err;
    clear_mon();
    send_header(addr, n, gap);
    for (int i = 0; i < 2 * n; i++) begin
      send_byte(data_q[i]);
      repeat (gap) tick();
    end
    if (n != 0) send_csum(corrupt);
    wait_done(tag);
`ifdef SPART_LOADER_CSUM_EN
    exp_csum_err = corrupt && (n != 0);
`else
    exp_csum_err = 1'b0;
`endif
    checkOutput({tag, "_load_cnt"},  64'(load_cnt), 64'd1);
    checkOutput({tag, "_done_cnt"},  64'(done_cnt), 64'd1);
    checkOutput({tag, "_start"},     64'(cap_start), 64'(exp_start));
    checkOutput({tag, "_end"},       64'(cap_end), 64'(exp_end));
    checkOutput({tag, "_word_cnt"},  64'(mon_words.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      exp_w = {data_q[2 * i + 1], data_q[2 * i]};
      if (i < mon_words.size())
        checkOutput($sformatf("%s_word%0d", tag, i), 64'(mon_words[i]), 64'(exp_w));
    end
    checkOutput({tag, "_req_seen"},  64'(req_cycles != 0), 64'(n != 0));
    checkOutput({tag, "_req_done"},  64'(req_at_done), 64'd0);
    checkOutput({tag, "_overrun"},   64'(err_overrun), 64'd0);
    checkOutput({tag, "_csum_err"},  64'(err_csum), 64'(exp_csum_err));
    checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_flags"},
                64'({busy, done, err_overrun, err_csum, bus_if.trxn_req,
                     bus_if.wr_req, bus_if.load_addr}), 64'd0);
    checkOutput({tag, "_start"},   64'(bus_if.start_addr), 64'd0);
    checkOutput({tag, "_end"},     64'(bus_if.end_addr), 64'd0);
    checkOutput({tag, "_wr_data"}, 64'(bus_if.wr_data), 64'd0);
  endtask

  typedef struct {
    logic [31:0]       addr;
    int                n;
    logic [ADDR_W-1:0] exp_start;
    logic [ADDR_W-1:0] exp_end;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0]       spec_w[2];
    logic [31:0]       ra;
    int                rn;
    int                rgap;

    vecs[0] = '{32'h0000_0100, 2, 25'h0000100, 25'h0000101};
    vecs[1] = '{32'hFE00_0010, 3, 25'h0000010, 25'h0000012};
    vecs[2] = '{32'h01FF_FFFF, 2, 25'h1FFFFFF, 25'h0000000};
    vecs[3] = '{32'h0000_0000, 0, 25'h0000000, 25'h1FFFFFF};
    vecs[4] = '{32'h0123_4567, 1, 25'h1234567, 25'h1234567};
    vecs[5] = '{32'h0000_0050, 0, 25'h0000050, 25'h000004F};
    vecs[6] = '{32'hFFFF_FFF0, 5, 25'h1FFFFF0, 25'h1FFFFF4};

    bus_if.trxn_grant = 1'b0;
    bus_if.wr_full    = 1'b0;
    tb_xor            = 8'h00;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Reference example frame.
    bus_if.trxn_grant = 1'b1;
    data_q = '{8'h34, 8'h12, 8'h78, 8'h56};
    applyStimulus("spec", 32'h0000_0100, 2, 25'h0000100, 25'h0000101, 2, 1'b0);
    spec_w[0] = 16'h1234;
    spec_w[1] = 16'h5678;
    for (int i = 0; i < 2; i++)
      if (i < mon_words.size())
        checkOutput($sformatf("spec_const_word%0d", i), 64'(mon_words[i]), 64'(spec_w[i]));

    // Write FIFO full held across the first word.
    clear_mon();
    bus_if.trxn_grant = 1'b1;
    bus_if.wr_full    = 1'b0;
    send_header(32'h0000_0200, 2, 1);
    repeat (3) tick();
    bus_if.wr_full = 1'b1;
    send_byte(8'hCD);
    tick();
    send_byte(8'hAB);
    repeat (10) tick();
    checkOutput("stall_no_push", 64'(mon_words.size()), 64'd0);
    bus_if.wr_full = 1'b0;
    repeat (3) tick();
    checkOutput("stall_word_cnt", 64'(mon_words.size()), 64'd1);
    checkOutput("stall_word", 64'((mon_words.size() > 0) ? mon_words[0] : 16'h0000), 64'hABCD);
    checkOutput("stall_overrun", 64'(err_overrun), 64'd0);
    send_byte(8'h22);
    send_byte(8'h11);
    send_csum(1'b0);
    wait_done("stall");
    checkOutput("stall_word1", 64'((mon_words.size() > 1) ? mon_words[1] : 16'h0000), 64'h1122);
    checkOutput("stall_done_cnt", 64'(done_cnt), 64'd1);

    // Grant withheld over three words: the fourth data byte overruns, then
    // the reset in DATA aborts the frame.
    clear_mon();
    bus_if.trxn_grant = 1'b0;
    send_header(32'h0000_0300, 3, 1);
    checkOutput("ovr_busy_mid", 64'(busy), 64'd1);
    send_byte(8'h11); tick();
    send_byte(8'h22); tick();
    send_byte(8'h33); tick();
    checkOutput("ovr_before", 64'(err_overrun), 64'd0);
    send_byte(8'h44);
    checkOutput("ovr_after", 64'(err_overrun), 64'd1);
    tick();
    send_byte(8'h55); tick();
    send_byte(8'h66); tick();
    checkOutput("ovr_no_push", 64'(mon_words.size()), 64'd0);
    checkOutput("ovr_req_held", 64'(bus_if.trxn_req), 64'd1);
    bus_if.trxn_grant = 1'b1;
    repeat (4) tick();
    checkOutput("ovr_push_cnt", 64'(mon_words.size()), 64'd1);
    checkOutput("ovr_push_word", 64'((mon_words.size() > 0) ? mon_words[0] : 16'h0000), 64'h2211);
    rst_n = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    tick();

    // Table of frames with known address windows.
    bus_if.trxn_grant = 1'b1;
    bus_if.wr_full    = 1'b0;
    for (int v = 0; v < 7; v++) begin
      fill_random(vecs[v].n);
      applyStimulus($sformatf("vec%0d", v), vecs[v].addr, vecs[v].n,
                    vecs[v].exp_start, vecs[v].exp_end, 2, 1'b0);
    end

`ifdef SPART_LOADER_CSUM_EN
    fill_random(2);
    applyStimulus("csum_bad", 32'h0000_0400, 2, 25'h0000400, 25'h0000401, 2, 1'b1);
    fill_random(2);
    applyStimulus("csum_good", 32'h0000_0500, 2, 25'h0000500, 25'h0000501, 2, 1'b0);
`endif

    // Randomized frames under random grant/full, checked against the model.
    rand_bus = 1'b1;
    for (int f = 0; f < 8; f++) begin
      ra   = $urandom;
      rn   = $urandom_range(0, 6);
      rgap = 4 + $urandom_range(0, 2);
      fill_random(rn);
      applyStimulus($sformatf("rand%0d", f), ra, rn, model_start(ra), model_end(ra, rn),
                    rgap, 1'b0);
    end
    rand_bus = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
